mesh_router_node: RTL and testbench
===================================

Name: mesh_router_node

Overview:
- Clocked, parametrised successor to the 4-in/4-out asynchronous NoC node.
- 5-port 2D-mesh router: Local, North, East, South, West.
- Each input has a DEPTH-entry FIFO; each output has a round-robin arbiter and a registered output stage.
- Routing is deterministic XY; flits addressed outside the mesh are dropped and counted.
- Flit format matches the existing 11-bit node flit at default widths.

Parameters:
- X_W, 2, width of the destination X field
- Y_W, 2, width of the destination Y field
- PAYLOAD_W, 7, payload width (Hamming-coded 7 bits by default)
- DEPTH, 4, input FIFO entries per port; power of two, >= 2
- MY_X, 0, this node's X coordinate
- MY_Y, 0, this node's Y coordinate
- MESH_X, 4, mesh columns; valid dest_x is 0..MESH_X-1
- MESH_Y, 4, mesh rows; valid dest_y is 0..MESH_Y-1
- FLIT_W is derived = X_W+Y_W+PAYLOAD_W (11 at defaults).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  5  per-port flit valid; bit0=L, 1=N, 2=E, 3=S, 4=W
- in_ready  out  5  per-port FIFO not full
- in_data  in  5*FLIT_W  port p at [p*FLIT_W +: FLIT_W]; flit = {dest_x, dest_y, payload}
- out_valid  out  5  registered output valid
- out_ready  in  5  downstream accept
- out_data  out  5*FLIT_W  registered output flits
- drop_pulse  out  1  one-cycle pulse per dropped flit
- drop_cnt  out  8  saturating count of dropped flits

Behaviour:
- Reset (sampled high on a clk edge): FIFO pointers/counts=0; out_valid=0; out_data=0; drop_pulse=0; drop_cnt=0; all RR pointers=4 so port 0 has top priority first. in_ready forced to 0 while reset is high.
- Input handshake: a transfer occurs on an edge with in_valid[p]&in_ready[p]. in_ready[p] = !full[p]. No push into a full FIFO even if it pops the same cycle. in_data must hold while in_valid is high and ready is low.
- Route of each FIFO head, combinational:
  - dest_x>=MESH_X or dest_y>=MESH_Y -> DROP
  - else dest_x>MY_X -> E; dest_x<MY_X -> W
  - else dest_y>MY_Y -> N; dest_y<MY_Y -> S
  - else Local
- A Local-input flit addressed to this node loops back to the Local output.
- DROP: the head is popped the cycle it appears, with no arbitration. drop_pulse=1 on the next cycle. drop_cnt increments, saturating at 255. Several drops in one cycle: pop all of them, pulse once, add the number of drops (saturating).
- Output stage o can load when !out_valid[o] | out_ready[o].
- When o can load, its arbiter grants among heads routed to o, searching from rr_ptr[o]+1 upward, mod 5. On grant:
  - pop the winning FIFO
  - out_data[o] <= head; out_valid[o] <= 1
  - rr_ptr[o] <= winner
- If no request and out_ready[o] is high, out_valid[o] <= 0. If o cannot load, the pointer does not change.
- An input head targets exactly one output, so each FIFO pops at most once per cycle. Different outputs grant independently in the same cycle.
- Output handshake: out_valid/out_data stay stable until out_ready is high on an edge. Back-to-back flits are allowed with no bubble, giving one flit/cycle/output throughput.
- Latency: a flit accepted at edge E0 into an empty FIFO with a free, uncontested output has out_valid high after edge E1.
- Flit order is preserved per (input, output) pair.
- Reset mid-operation: all buffered and in-flight flits are discarded and no output is asserted in the cycle after reset. drop_cnt clears.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- MY=(1,1). Local sends {x=3,y=1,p=0x55} -> E out_valid after 1 edge with data 0x6D5. In order: {1,3} -> N, {1,0} -> S, {0,1} -> W, {1,1} -> Local.
- N, E, S, W each inject one flit to Local in the same cycle, out_ready=1 -> Local outputs N, E, S, W in consecutive cycles; repeat the pattern -> grant order continues rotating round-robin.
- Local out_ready=0 for 10 cycles while E streams Local-bound flits -> exactly DEPTH+1 accepted, in_ready[2]=0 afterwards. Release -> all delivered in order, no loss or duplication.
- MESH_X=3; flit dest_x=3 -> drop_pulse for one cycle, drop_cnt=1, no out_valid. 300 such flits -> drop_cnt=255.
- Reset asserted for 1 cycle while 3 flits are buffered and out_valid is high -> out_valid=0 and in_ready=0 during reset. Afterwards in_ready=5'b11111, and none of the old flits ever appear.

Source files
------------

// File: rtl/mesh_router_node.sv
// 5-port XY-routed mesh router node: per-input FIFOs, per-output round-robin
// arbitration into registered output stages, and out-of-mesh flit dropping.
module mesh_router_node #(
  parameter int X_W       = 2,
  parameter int Y_W       = 2,
  parameter int PAYLOAD_W = 7,
  parameter int DEPTH     = 4,
  parameter int MY_X      = 0,
  parameter int MY_Y      = 0,
  parameter int MESH_X    = 4,
  parameter int MESH_Y    = 4,
  localparam int FLIT_W   = X_W + Y_W + PAYLOAD_W
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [4:0]          i_in_valid,
  output logic [4:0]          o_in_ready,
  input  logic [5*FLIT_W-1:0] i_in_data,
  output logic [4:0]          o_out_valid,
  input  logic [4:0]          i_out_ready,
  output logic [5*FLIT_W-1:0] o_out_data,
  output logic                o_drop_pulse,
  output logic [7:0]          o_drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] ROUTE_DROP = 3'd5;

  logic [FLIT_W-1:0] r_mem [5][DEPTH];
  logic [PTR_W-1:0]  r_wrPtr [5];
  logic [PTR_W-1:0]  r_rdPtr [5];
  logic [CNT_W-1:0]  r_count [5];

  logic [4:0]        r_outValid;
  logic [FLIT_W-1:0] r_outData [5];
  logic [2:0]        r_rrPtr [5];
  logic              r_dropPulse;
  logic [7:0]        r_dropCnt;

  logic [4:0]        w_push;
  logic [4:0]        w_pop;
  logic [4:0]        w_headValid;
  logic [4:0]        w_drop;
  logic [FLIT_W-1:0] w_head [5];
  logic [2:0]        w_route [5];
  logic [4:0]        w_canLoad;
  logic [4:0]        w_grantValid;
  logic [2:0]        w_winner [5];
  logic [2:0]        w_dropNum;
  logic [8:0]        w_dropSum;

  // Output port numbering: 0=Local, 1=North, 2=East, 3=South, 4=West.
  function automatic logic [2:0] routeOf(input logic [FLIT_W-1:0] flit);
    int dx;
    int dy;
    dx = int'(flit[FLIT_W-1 -: X_W]);
    dy = int'(flit[PAYLOAD_W +: Y_W]);
    if (dx >= MESH_X || dy >= MESH_Y) return ROUTE_DROP;
    else if (dx > MY_X)               return 3'd2;
    else if (dx < MY_X)               return 3'd4;
    else if (dy > MY_Y)               return 3'd1;
    else if (dy < MY_Y)               return 3'd3;
    else                              return 3'd0;
  endfunction

  function automatic logic [2:0] rrIndex(input logic [2:0] ptr, input int step);
    return 3'((int'(ptr) + step) % 5);
  endfunction

  always_comb begin
    for (int p = 0; p < 5; p++) begin
      w_headValid[p] = (r_count[p] != '0);
      w_head[p]      = r_mem[p][r_rdPtr[p]];
      w_route[p]     = routeOf(w_head[p]);
      w_drop[p]      = w_headValid[p] && (w_route[p] == ROUTE_DROP);
      o_in_ready[p]  = !i_reset && (r_count[p] != CNT_W'(DEPTH));
      w_push[p]      = i_in_valid[p] && o_in_ready[p];
    end
  end

  // Dropped heads leave without arbitration; every other head competes only
  // for its single routed output, so a FIFO never pops twice in one cycle.
  always_comb begin
    w_pop = w_drop;
    for (int o = 0; o < 5; o++) begin
      w_canLoad[o]    = !r_outValid[o] || i_out_ready[o];
      w_grantValid[o] = 1'b0;
      w_winner[o]     = 3'd0;
      for (int k = 1; k <= 5; k++) begin
        if (!w_grantValid[o] && w_headValid[rrIndex(r_rrPtr[o], k)] &&
            (w_route[rrIndex(r_rrPtr[o], k)] == 3'(o))) begin
          w_grantValid[o] = 1'b1;
          w_winner[o]     = rrIndex(r_rrPtr[o], k);
        end
      end
      if (w_canLoad[o] && w_grantValid[o]) w_pop[w_winner[o]] = 1'b1;
    end
  end

  always_comb begin
    w_dropNum = '0;
    for (int p = 0; p < 5; p++) w_dropNum = w_dropNum + 3'(w_drop[p]);
    w_dropSum = {1'b0, r_dropCnt} + 9'(w_dropNum);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int p = 0; p < 5; p++) begin
        r_wrPtr[p] <= '0;
        r_rdPtr[p] <= '0;
        r_count[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (w_push[p]) begin
          r_mem[p][r_wrPtr[p]] <= i_in_data[p*FLIT_W +: FLIT_W];
          r_wrPtr[p]           <= r_wrPtr[p] + PTR_W'(1);
        end
        if (w_pop[p]) r_rdPtr[p] <= r_rdPtr[p] + PTR_W'(1);
        r_count[p] <= r_count[p] + CNT_W'(w_push[p]) - CNT_W'(w_pop[p]);
      end
    end
  end

  // Pointer reset to 4 makes port 0 the first in line after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_outValid  <= '0;
      r_dropPulse <= 1'b0;
      r_dropCnt   <= '0;
      for (int o = 0; o < 5; o++) begin
        r_outData[o] <= '0;
        r_rrPtr[o]   <= 3'd4;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (w_canLoad[o] && w_grantValid[o]) begin
          r_outData[o]  <= w_head[w_winner[o]];
          r_outValid[o] <= 1'b1;
          r_rrPtr[o]    <= w_winner[o];
        end else if (i_out_ready[o]) begin
          r_outValid[o] <= 1'b0;
        end
      end
      r_dropPulse <= |w_drop;
      r_dropCnt   <= w_dropSum[8] ? 8'hFF : w_dropSum[7:0];
    end
  end

  always_comb begin
    o_out_data = '0;
    for (int o = 0; o < 5; o++) o_out_data[o*FLIT_W +: FLIT_W] = r_outData[o];
  end

  assign o_out_valid  = r_outValid;
  assign o_drop_pulse = r_dropPulse;
  assign o_drop_cnt   = r_dropCnt;

endmodule

// File: tb/tb_mesh_router_node.sv
// Directed bench for mesh_router_node: node A sits at (1,1) in a 4x4 mesh,
// node B at (1,1) in a 3-column mesh so that dest_x=3 is out of range.
module tb_mesh_router_node;

  logic        clk;
  logic        reset;

  logic [4:0]  aValid;
  logic [4:0]  aReady;
  logic [54:0] aData;
  logic [4:0]  aOutValid;
  logic [4:0]  aOutReady;
  logic [54:0] aOutData;
  logic        aDropPulse;
  logic [7:0]  aDropCnt;

  logic [4:0]  bValid;
  logic [4:0]  bReady;
  logic [54:0] bData;
  logic [4:0]  bOutValid;
  logic [4:0]  bOutReady;
  logic [54:0] bOutData;
  logic        bDropPulse;
  logic [7:0]  bDropCnt;

  int testCount;
  int failCount;

  mesh_router_node #(.MY_X(1), .MY_Y(1), .MESH_X(4), .MESH_Y(4)) dutA (
    .i_clk(clk), .i_reset(reset),
    .i_in_valid(aValid), .o_in_ready(aReady), .i_in_data(aData),
    .o_out_valid(aOutValid), .i_out_ready(aOutReady), .o_out_data(aOutData),
    .o_drop_pulse(aDropPulse), .o_drop_cnt(aDropCnt)
  );

  mesh_router_node #(.MY_X(1), .MY_Y(1), .MESH_X(3), .MESH_Y(4)) dutB (
    .i_clk(clk), .i_reset(reset),
    .i_in_valid(bValid), .o_in_ready(bReady), .i_in_data(bData),
    .o_out_valid(bOutValid), .i_out_ready(bOutReady), .o_out_data(bOutData),
    .o_drop_pulse(bDropPulse), .o_drop_cnt(bDropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] mkFlit(input int x, input int y, input int p);
    return {x[1:0], y[1:0], p[6:0]};
  endfunction

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic [10:0] flit, input logic v);
    aData[port*11 +: 11] = flit;
    aValid[port]         = v;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int tx[5];
    int ty[5];
    int tp[5];
    int tPort[5];
    int sent;
    int got;
    logic rdy;
    logic [4:0] seen;

    testCount = 0;
    failCount = 0;
    reset     = 1'b1;
    aValid    = '0;
    aData     = '0;
    aOutReady = 5'b11111;
    bValid    = '0;
    bData     = '0;
    bOutReady = 5'b11111;

    // Reset state
    stepClk();
    checkOutput("rstInReady", aReady, 5'b00000);
    checkOutput("rstOutValid", aOutValid, 5'b00000);
    checkOutput("rstOutData", aOutData, 55'd0);
    checkOutput("rstDropCnt", bDropCnt, 8'd0);
    stepClk();
    reset = 1'b0;
    #1;
    checkOutput("postRstReady", aReady, 5'b11111);

    // XY routing from the Local input, one flit at a time
    tx = '{3, 1, 1, 0, 1};
    ty = '{1, 3, 0, 1, 1};
    tp = '{8'h55, 8'h11, 8'h22, 8'h33, 8'h44};
    tPort = '{2, 1, 3, 4, 0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, mkFlit(tx[i], ty[i], tp[i]), 1'b1);
      stepClk();
      applyStimulus(0, 11'd0, 1'b0);
      stepClk();
      checkOutput("routeValid", aOutValid, 64'(5'b00001 << tPort[i]));
      checkOutput("routeData", aOutData[tPort[i]*11 +: 11], mkFlit(tx[i], ty[i], tp[i]));
      if (i == 0) checkOutput("eastLiteral", aOutData[2*11 +: 11], 11'h6D5);
    end

    // Round-robin: N,E,S,W all target Local in the same cycle
    for (int p = 1; p < 5; p++) applyStimulus(p, mkFlit(1, 1, 8'h10 + p), 1'b1);
    stepClk();
    for (int p = 1; p < 5; p++) applyStimulus(p, 11'd0, 1'b0);
    for (int p = 1; p < 5; p++) begin
      stepClk();
      checkOutput("rr1Valid", aOutValid, 5'b00001);
      checkOutput("rr1Data", aOutData[10:0], mkFlit(1, 1, 8'h10 + p));
    end

    // Second round: a late North flit must wait behind E, S, W
    for (int p = 1; p < 5; p++) applyStimulus(p, mkFlit(1, 1, 8'h20 + p), 1'b1);
    stepClk();
    for (int p = 2; p < 5; p++) applyStimulus(p, 11'd0, 1'b0);
    applyStimulus(1, mkFlit(1, 1, 8'h2F), 1'b1);
    stepClk();
    applyStimulus(1, 11'd0, 1'b0);
    checkOutput("rr2N", aOutData[10:0], mkFlit(1, 1, 8'h21));
    stepClk();
    checkOutput("rr2E", aOutData[10:0], mkFlit(1, 1, 8'h22));
    stepClk();
    checkOutput("rr2S", aOutData[10:0], mkFlit(1, 1, 8'h23));
    stepClk();
    checkOutput("rr2W", aOutData[10:0], mkFlit(1, 1, 8'h24));
    stepClk();
    checkOutput("rr2N2", aOutData[10:0], mkFlit(1, 1, 8'h2F));
    checkOutput("rr2Valid", aOutValid, 5'b00001);
    stepClk();

    // Backpressure: Local output stalled while East streams Local-bound flits
    aOutReady[0] = 1'b0;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(2, mkFlit(1, 1, 8'h40 + sent), 1'b1);
      rdy = aReady[2];
      stepClk();
      if (rdy) sent++;
    end
    applyStimulus(2, 11'd0, 1'b0);
    checkOutput("stallAccepted", 64'(sent), 64'd5);
    checkOutput("stallReady", aReady[2], 1'b0);
    checkOutput("stallHoldValid", aOutValid[0], 1'b1);
    checkOutput("stallHoldData", aOutData[10:0], mkFlit(1, 1, 8'h40));
    aOutReady[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 15; c++) begin
      if (aOutValid[0]) begin
        checkOutput("stallOrder", aOutData[10:0], mkFlit(1, 1, 8'h40 + got));
        got++;
      end
      stepClk();
    end
    checkOutput("stallDelivered", 64'(got), 64'd5);

    // Out-of-mesh drop on node B
    bValid[0]    = 1'b1;
    bData[10:0]  = mkFlit(3, 0, 8'h01);
    stepClk();
    bValid = '0;
    stepClk();
    checkOutput("dropPulse", bDropPulse, 1'b1);
    checkOutput("dropCnt1", bDropCnt, 8'd1);
    checkOutput("dropNoOut", bOutValid, 5'b00000);
    stepClk();
    checkOutput("dropPulseEnd", bDropPulse, 1'b0);

    // Five simultaneous drops add five
    for (int p = 0; p < 5; p++) bData[p*11 +: 11] = mkFlit(3, 2, p);
    bValid = 5'b11111;
    stepClk();
    bValid = '0;
    stepClk();
    checkOutput("multiDropPulse", bDropPulse, 1'b1);
    checkOutput("multiDropCnt", bDropCnt, 8'd6);
    stepClk();
    checkOutput("multiDropPulseEnd", bDropPulse, 1'b0);

    // 300 more drops saturate the counter
    bValid = 5'b11111;
    for (int c = 0; c < 60; c++) stepClk();
    bValid = '0;
    for (int c = 0; c < 3; c++) stepClk();
    checkOutput("dropSaturate", bDropCnt, 8'd255);
    checkOutput("dropSatNoOut", bOutValid, 5'b00000);
    checkOutput("dropSatReady", bReady, 5'b11111);
    checkOutput("aNoDrops", aDropCnt, 8'd0);

    // Mid-operation reset with three flits buffered and Local output valid
    aOutReady[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2, mkFlit(1, 1, 8'h60 + i), 1'b1);
      stepClk();
    end
    applyStimulus(2, 11'd0, 1'b0);
    checkOutput("preRstValid", aOutValid, 5'b00001);
    reset = 1'b1;
    #1;
    checkOutput("midRstReadyLow", aReady, 5'b00000);
    stepClk();
    checkOutput("midRstValid", aOutValid, 5'b00000);
    checkOutput("midRstReady", aReady, 5'b00000);
    checkOutput("midRstDropCnt", bDropCnt, 8'd0);
    reset = 1'b0;
    aOutReady = 5'b11111;
    #1;
    checkOutput("afterRstReady", aReady, 5'b11111);
    seen = '0;
    for (int c = 0; c < 10; c++) begin
      stepClk();
      seen = seen | aOutValid;
    end
    checkOutput("noStaleFlits", seen, 5'b00000);

    // Fresh loopback after reset works normally
    applyStimulus(0, mkFlit(1, 1, 8'h2A), 1'b1);
    stepClk();
    applyStimulus(0, 11'd0, 1'b0);
    stepClk();
    checkOutput("freshValid", aOutValid, 5'b00001);
    checkOutput("freshData", aOutData[10:0], 11'h2AA);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
